instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Loads a program into instruction memory before the pipeline runs.
- Sits between the debug UART receiver and instruction memory.
- Takes a byte stream, packs it into 32-bit instructions and writes them to consecutive word addresses.
- Stops at the halt instruction, then flags the program as loaded so the pipeline can fetch the words that the control decoder consumes.

Parameters:
- N_BITS, 32, instruction width; fixed at 4 bytes per word.
- N_BITS_OP, 6, opcode field width (bits [31:26]).
- N_ADDR, 8, instruction memory word-address width; depth = 2**N_ADDR.
- HALT_OP, 6'b111111, opcode that terminates loading.

Ports:
- i_clk, in, 1, system clock.
- i_reset, in, 1, reset.
- i_rx_data, in, 8, received byte; valid only while i_rx_done=1.
- i_rx_done, in, 1, one-cycle strobe: a byte is available.
- i_clear, in, 1, return from DONE/ERROR to IDLE for a reload.
- o_mem_wr_en, out, 1, one-cycle instruction-memory write strobe.
- o_mem_addr, out, N_ADDR, word address for the write.
- o_mem_data, out, N_BITS, instruction word to write.
- o_load_done, out, 1, level: program loaded, halt word written.
- o_error, out, 1, level: memory overflow (or checksum mismatch, see below).
- o_word_count, out, N_ADDR+1, number of words written, including halt.

Interface rule: one clock (i_clk); reset i_reset is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, any state, including mid-word):
  - State goes to IDLE.
  - All outputs are 0; byte index is 0; address is 0; word register is 0.
  - A partially assembled word is discarded.
- States: IDLE, LOAD, DONE, ERROR, plus CHECK (feature only).
- IDLE:
  - First i_rx_done captures byte 0 into word[31:24], sets byte index to 1 and moves to LOAD.
- LOAD:
  - Each strobe stores the byte at word[31-8k -: 8] for k = byte index. Ordering is MSB first (big-endian).
  - On the 4th byte (k=3), the next cycle drives o_mem_wr_en=1 for exactly 1 cycle, with o_mem_addr = current address and o_mem_data = the assembled word.
  - Address and o_word_count increment in the same cycle as the write. Byte index wraps to 0.
  - Write latency: 1 cycle after the 4th strobe.
  - A strobe arriving in the write cycle is accepted as byte 0 of the next word; no byte is lost.
- Halt detection: the written word has [31:26]==HALT_OP.
  - The halt word is still written.
  - The cycle after the write, the block enters DONE and o_load_done=1.
- Overflow: a non-halt word written at address 2**N_ADDR-1 moves the block to ERROR with o_error=1. The address does not wrap.
- DONE / ERROR:
  - Strobes are ignored.
  - Outputs hold, with o_mem_wr_en=0.
  - i_clear=1 returns to IDLE and clears o_load_done, o_error, address, o_word_count and byte index, all in 1 cycle.
- i_clear in IDLE or LOAD aborts the load with the same clearing action. If i_clear and i_rx_done are high together, clear wins and the byte is dropped.
- No write ever occurs outside LOAD.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR covers every program byte, including the halt word's bytes.
  - After the halt write the block goes to CHECK and waits for one more byte.
  - If that byte equals the XOR, go to DONE (o_load_done=1). Otherwise go to ERROR (o_error=1).
  - The checksum byte is never written to memory.
  - i_clear in CHECK aborts to IDLE.
- Disabled: no CHECK state; the halt write goes straight to DONE.

Test Plan:
- Bytes 20,08,00,05 then FC,00,00,00 -> write addr0 data 0x20080005; write addr1 data 0xFC000000; o_load_done=1 next cycle; o_word_count=2.
- 3 bytes of a word, then i_reset pulse mid-cycle, then 8C,01,00,04,FF,FF,FF,FF -> addr0=0x8C010004, addr1=0xFFFFFFFF; o_load_done=1; no stale bytes.
- N_ADDR=2, five non-halt words -> writes at addr 0..3, ERROR after the 4th write; 5th word bytes ignored; o_error=1, o_word_count=4.
- Strobe in the same cycle as o_mem_wr_en -> that byte becomes word[31:24] of the next word; next write is correct.
- In DONE, send 4 bytes -> no write; then i_clear -> IDLE, all outputs 0; reload writes at addr0.
- INSTR_LOADER_CHECKSUM_EN: program FC,00,00,00 then byte FC -> DONE. Same program then byte 00 -> ERROR. Memory holds only 0xFC000000 at addr0 in both cases.

Source files
------------

// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream input and instruction-memory write bus of the
// program loader.
//   i_rx_data/i_rx_done : received byte and its one-cycle valid strobe
//   i_clear             : return to IDLE (abort or reload)
//   o_mem_wr_en/addr/data : one-cycle instruction-memory write
//   o_load_done/o_error : status levels
//   o_word_count        : words written, including the halt word
// Modports: slave = loader view, master = byte source / memory / host view.
interface instr_loader_if #(
  parameter int unsigned N_BITS = 32,
  parameter int unsigned N_ADDR = 8
);
  logic [7:0]        i_rx_data;
  logic              i_rx_done;
  logic              i_clear;
  logic              o_mem_wr_en;
  logic [N_ADDR-1:0] o_mem_addr;
  logic [N_BITS-1:0] o_mem_data;
  logic              o_load_done;
  logic              o_error;
  logic [N_ADDR:0]   o_word_count;

  modport slave (
    input  i_rx_data, i_rx_done, i_clear,
    output o_mem_wr_en, o_mem_addr, o_mem_data, o_load_done, o_error, o_word_count
  );

  modport master (
    output i_rx_data, i_rx_done, i_clear,
    input  o_mem_wr_en, o_mem_addr, o_mem_data, o_load_done, o_error, o_word_count
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: packs a received byte stream (MSB first) into 32-bit
// instructions and writes them to consecutive instruction-memory words.
// Loading stops after the halt word (opcode HALT_OP) is written; o_load_done
// then stays high until i_clear. Writing a non-halt word to the last address
// flags o_error instead (address does not wrap).
// Ports: i_clk, i_reset (async, active-high), bus (instr_loader_if.slave).
// Optional: define INSTR_LOADER_CHECKSUM_EN to require one trailing byte equal
// to the XOR of all program bytes before o_load_done is raised.
module instr_loader #(
  parameter int unsigned            N_BITS    = 32,
  parameter int unsigned            N_BITS_OP = 6,
  parameter int unsigned            N_ADDR    = 8,
  parameter logic [N_BITS_OP-1:0]   HALT_OP   = '1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  instr_loader_if.slave   bus
);

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERROR, ST_CHECK} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERROR} state_t;
`endif

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [N_BITS-1:0] word_q, word_d;
  logic [N_ADDR-1:0] addr_q, addr_d;
  logic [N_ADDR:0]   word_count_q, word_count_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [N_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [N_BITS-1:0] mem_data_q, mem_data_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept;
  logic [N_BITS-1:0] word_next;
  logic              wr_is_halt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    mem_wr_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    accept       = 1'b0;

    word_next = word_q;
    word_next[(N_BITS-1) - 8*int'(byte_idx_q) -: 8] = bus.i_rx_data;

    wr_is_halt = (mem_data_q[N_BITS-1 -: N_BITS_OP] == HALT_OP);

    case (state_q)
      ST_IDLE: begin
        if (bus.i_rx_done) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The halt/overflow decision is taken during the write cycle, so the
        // status state appears one cycle after the write; a byte arriving in
        // that cycle is only kept when loading continues.
        if (mem_wr_en_q && wr_is_halt) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          if (bus.i_rx_done) begin
            state_d = (bus.i_rx_data == csum_q) ? ST_DONE : ST_ERROR;
          end else begin
            state_d = ST_CHECK;
          end
`else
          state_d = ST_DONE;
`endif
        end else if (mem_wr_en_q && (mem_addr_q == '1)) begin
          state_d = ST_ERROR;
        end else if (bus.i_rx_done) begin
          accept = 1'b1;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (bus.i_rx_done) begin
          state_d = (bus.i_rx_data == csum_q) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      default: begin
      end
    endcase

    if (accept) begin
      word_d = word_next;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_d = csum_q ^ bus.i_rx_data;
`endif
      if (byte_idx_q == 2'd3) begin
        byte_idx_d   = '0;
        mem_wr_en_d  = 1'b1;
        mem_addr_d   = addr_q;
        mem_data_d   = word_next;
        // Saturate at the last word; the overflow check uses mem_addr_q.
        addr_d       = (addr_q == '1) ? addr_q : addr_q + 1'b1;
        word_count_d = word_count_q + 1'b1;
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end

    // Clear has priority over any byte received in the same cycle.
    if (bus.i_clear) begin
      state_d      = ST_IDLE;
      byte_idx_d   = '0;
      word_d       = '0;
      addr_d       = '0;
      word_count_d = '0;
      mem_wr_en_d  = 1'b0;
      mem_addr_d   = '0;
      mem_data_d   = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_d       = '0;
`endif
    end
  end

  assign bus.o_mem_wr_en  = mem_wr_en_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_data   = mem_data_q;
  assign bus.o_load_done  = (state_q == ST_DONE);
  assign bus.o_error      = (state_q == ST_ERROR);
  assign bus.o_word_count = word_count_q;

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
module tb_instr_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_loader_if #(.N_BITS(32), .N_ADDR(8)) bus_a ();
  instr_loader_if #(.N_BITS(32), .N_ADDR(2)) bus_b ();

  instr_loader #(.N_BITS(32), .N_BITS_OP(6), .N_ADDR(8), .HALT_OP(6'b111111)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(bus_a)
  );
  instr_loader #(.N_BITS(32), .N_BITS_OP(6), .N_ADDR(2), .HALT_OP(6'b111111)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned last_edge = 0;
  logic [7:0] csum_m;

  // write record: {edge index, 8-bit address, 32-bit data}
  logic [71:0] exp_a[$];
  logic [71:0] exp_b[$];
  logic [71:0] obs_a[$];
  logic [71:0] obs_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_a.o_mem_wr_en === 1'b1)
      obs_a.push_back({32'(cyc), bus_a.o_mem_addr, bus_a.o_mem_data});
    if (bus_b.o_mem_wr_en === 1'b1)
      obs_b.push_back({32'(cyc), 6'b0, bus_b.o_mem_addr, bus_b.o_mem_data});
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_a(input string tag, input logic wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic done, input logic err,
                       input logic [8:0] cnt);
    chk({tag, " wr_en"},  32'(bus_a.o_mem_wr_en),  32'(wr));
    chk({tag, " addr"},   32'(bus_a.o_mem_addr),   32'(addr));
    chk({tag, " data"},   bus_a.o_mem_data,        data);
    chk({tag, " done"},   32'(bus_a.o_load_done),  32'(done));
    chk({tag, " error"},  32'(bus_a.o_error),      32'(err));
    chk({tag, " count"},  32'(bus_a.o_word_count), 32'(cnt));
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe one byte for one cycle; back-to-back calls give consecutive strobes.
  task automatic drive_byte(input bit to_b, input logic [7:0] b);
    if (to_b) begin
      bus_b.i_rx_data = b;
      bus_b.i_rx_done = 1'b1;
    end else begin
      bus_a.i_rx_data = b;
      bus_a.i_rx_done = 1'b1;
    end
    @(posedge clk);
    #1;
    last_edge = cyc;
    bus_a.i_rx_done = 1'b0;
    bus_b.i_rx_done = 1'b0;
  endtask

  task automatic send_word(input bit to_b, input logic [7:0] addr, input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int unsigned k = 0; k < 4; k++) begin
      drive_byte(to_b, t[31:24]);
      csum_m = csum_m ^ t[31:24];
      t = t << 8;
    end
    if (to_b) exp_b.push_back({32'(last_edge), addr, w});
    else      exp_a.push_back({32'(last_edge), addr, w});
  endtask

  task automatic end_program(input bit to_b);
`ifdef INSTR_LOADER_CHECKSUM_EN
    drive_byte(to_b, csum_m);
`else
    if (to_b) step(0);
`endif
    step(2);
  endtask

  task automatic check_writes(input bit to_b, input string tag);
    logic [71:0] e, o;
    while ((to_b ? exp_b.size() : exp_a.size()) > 0) begin
      e = to_b ? exp_b.pop_front() : exp_a.pop_front();
      if ((to_b ? obs_b.size() : obs_a.size()) > 0)
        o = to_b ? obs_b.pop_front() : obs_a.pop_front();
      else
        o = 'x;
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s write {edge,addr,data}: observed %h expected %h", tag, o, e);
      end
    end
    checks++;
    assert ((to_b ? obs_b.size() : obs_a.size()) == 0) else begin
      errors++;
      $error("FAIL %s extra writes: observed %0d expected 0", tag,
             to_b ? obs_b.size() : obs_a.size());
    end
    obs_a.delete();
    obs_b.delete();
  endtask

  task automatic clear_a();
    bus_a.i_clear = 1'b1;
    step(1);
    bus_a.i_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.i_rx_data = '0; bus_a.i_rx_done = 1'b0; bus_a.i_clear = 1'b0;
    bus_b.i_rx_data = '0; bus_b.i_rx_done = 1'b0; bus_b.i_clear = 1'b0;
    step(2);
    chk_a("reset", 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 9'd0);
    rst = 1'b0;
    step(1);

    // Basic two-word program; FC arrives in the write cycle of word 0.
    csum_m = '0;
    send_word(1'b0, 8'd0, 32'h2008_0005);
    send_word(1'b0, 8'd1, 32'hFC00_0000);
    chk("halt write strobe", 32'(bus_a.o_mem_wr_en), 32'd1);
    chk("done low in write cycle", 32'(bus_a.o_load_done), 32'd0);
`ifndef INSTR_LOADER_CHECKSUM_EN
    step(1);
    chk("done one cycle after halt write", 32'(bus_a.o_load_done), 32'd1);
`endif
    end_program(1'b0);
    check_writes(1'b0, "prog1");
    chk_a("prog1 status", 1'b0, 8'd1, 32'hFC00_0000, 1'b1, 1'b0, 9'd2);

    // Strobes in DONE are ignored.
    for (int unsigned i = 0; i < 4; i++) drive_byte(1'b0, 8'hA0 + 8'(i));
    step(2);
    check_writes(1'b0, "done ignore");
    chk_a("done hold", 1'b0, 8'd1, 32'hFC00_0000, 1'b1, 1'b0, 9'd2);

    clear_a();
    chk_a("after clear", 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 9'd0);

    // Partial word discarded by an asynchronous reset pulse mid-cycle.
    drive_byte(1'b0, 8'h11);
    drive_byte(1'b0, 8'h22);
    drive_byte(1'b0, 8'h33);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_a("mid reset", 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 9'd0);
    step(1);
    csum_m = '0;
    send_word(1'b0, 8'd0, 32'h8C01_0004);
    send_word(1'b0, 8'd1, 32'hFFFF_FFFF);
    end_program(1'b0);
    check_writes(1'b0, "prog2");
    chk_a("prog2 status", 1'b0, 8'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 9'd2);
    clear_a();

    // Clear during LOAD, together with a strobe: the byte is dropped.
    drive_byte(1'b0, 8'h11);
    drive_byte(1'b0, 8'h22);
    bus_a.i_rx_data = 8'h33;
    bus_a.i_rx_done = 1'b1;
    bus_a.i_clear   = 1'b1;
    step(1);
    bus_a.i_rx_done = 1'b0;
    bus_a.i_clear   = 1'b0;
    chk_a("abort clear", 1'b0, 8'd0, 32'h0, 1'b0, 1'b0, 9'd0);
    csum_m = '0;
    send_word(1'b0, 8'd0, 32'hFC00_0000);
    end_program(1'b0);
    check_writes(1'b0, "after abort");
    chk_a("after abort status", 1'b0, 8'd0, 32'hFC00_0000, 1'b1, 1'b0, 9'd1);
    clear_a();

    // Overflow on the 4-word memory: 5th word is never written.
    csum_m = '0;
    for (int unsigned i = 0; i < 4; i++)
      send_word(1'b1, 8'(i), 32'h0000_0001 + i);
    for (int unsigned k = 0; k < 4; k++) drive_byte(1'b1, 8'h05);
    step(2);
    check_writes(1'b1, "overflow");
    chk("overflow error", 32'(bus_b.o_error), 32'd1);
    chk("overflow done", 32'(bus_b.o_load_done), 32'd0);
    chk("overflow count", 32'(bus_b.o_word_count), 32'd4);
    chk("overflow addr hold", 32'(bus_b.o_mem_addr), 32'd3);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Correct checksum after a pause (waits in CHECK), then a wrong one.
    csum_m = '0;
    send_word(1'b0, 8'd0, 32'hFC00_0000);
    step(3);
    chk("csum waiting", 32'(bus_a.o_load_done), 32'd0);
    drive_byte(1'b0, 8'hFC);
    step(1);
    check_writes(1'b0, "csum good");
    chk_a("csum good status", 1'b0, 8'd0, 32'hFC00_0000, 1'b1, 1'b0, 9'd1);
    clear_a();
    send_word(1'b0, 8'd0, 32'hFC00_0000);
    step(1);
    drive_byte(1'b0, 8'h00);
    step(1);
    check_writes(1'b0, "csum bad");
    chk_a("csum bad status", 1'b0, 8'd0, 32'hFC00_0000, 1'b0, 1'b1, 9'd1);
    clear_a();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
